moore_run_detector: RTL

Parametrised Moore-style run-length detector. Watches serial input w and asserts z while the current run of matching bits has reached a runtime-programmable threshold. Adds bit-polarity mode, enable, synchronous clear, a rising-edge pulse and a saturating hit-event counter. With CW=2, Thresh=2, Mode=0 and En=1, z is cycle-identical to the team's existing two-consecutive-ones Moore detector.

---
 rtl/moore_run_detector.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/moore_run_detector.sv
// ---------------------------------------------------------------------------
// moore_run_detector
// Moore-style run-length detector. Tracks the current run of "matching" bits
// on serial input w (ones when Mode=0, zeros when Mode=1) and raises z while
// the run has reached the programmable threshold. Also provides a one-cycle
// rising-edge pulse and a saturating count of HIT entries.
//
// Parameters:
//   CW      width of run-length counter and Thresh (max run 2^CW-1)
//   EVW     width of hit-event counter
// Ports:
//   Clock   rising-edge clock
//   Resetn  asynchronous active-low reset
//   En      advance enable; 0 holds all state
//   Clear   synchronous clear of FSM and counters (overrides En)
//   Mode    0 = runs of 1s, 1 = runs of 0s
//   Thresh  run length required for a hit; 0 behaves as 1
//   w       serial data bit
//   z       high while FSM is in HIT (registered)
//   z_rise  one-cycle pulse on HIT entry (registered)
//   run_len current run length, saturating
//   evt_cnt number of IDLE/RUN->HIT entries, saturating
// ---------------------------------------------------------------------------
module moore_run_detector #(
    parameter int CW  = 4,
    parameter int EVW = 8
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           En,
    input  logic           Clear,
    input  logic           Mode,
    input  logic [CW-1:0]  Thresh,
    input  logic           w,
    output logic           z,
    output logic           z_rise,
    output logic [CW-1:0]  run_len,
    output logic [EVW-1:0] evt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HIT  = 2'b10
    } state_t;

    localparam logic [CW-1:0]  RUN_MAX = {CW{1'b1}};
    localparam logic [EVW-1:0] EVT_MAX = {EVW{1'b1}};

    state_t         state_r;
    logic           z_r;
    logic           z_rise_r;
    logic [CW-1:0]  run_len_r;
    logic [EVW-1:0] evt_cnt_r;

    logic           m_s;
    logic           state_ok_s;
    logic [CW-1:0]  thr_s;
    logic [CW-1:0]  run_inc_s;
    logic [EVW-1:0] evt_inc_s;

    // Next-value helpers: match bit, effective threshold, saturating increments.
    always_comb begin
        m_s        = w ^ Mode;
        state_ok_s = (state_r == ST_IDLE) || (state_r == ST_RUN) || (state_r == ST_HIT);
        if (Thresh == {CW{1'b0}}) begin
            thr_s = CW'(1'b1);
        end else begin
            thr_s = Thresh;
        end
        if (run_len_r == RUN_MAX) begin
            run_inc_s = RUN_MAX;
        end else begin
            run_inc_s = run_len_r + CW'(1'b1);
        end
        if (evt_cnt_r == EVT_MAX) begin
            evt_inc_s = EVT_MAX;
        end else begin
            evt_inc_s = evt_cnt_r + EVW'(1'b1);
        end
    end

    // FSM, run/event counters and registered z / z_rise.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r   <= ST_IDLE;
            run_len_r <= {CW{1'b0}};
            evt_cnt_r <= {EVW{1'b0}};
            z_r       <= 1'b0;
            z_rise_r  <= 1'b0;
        end else if (Clear) begin
            state_r   <= ST_IDLE;
            run_len_r <= {CW{1'b0}};
            evt_cnt_r <= {EVW{1'b0}};
            z_r       <= 1'b0;
            z_rise_r  <= 1'b0;
        end else if (!state_ok_s) begin
            // Corrupted encoding: recover regardless of En.
            state_r   <= ST_IDLE;
            run_len_r <= {CW{1'b0}};
            z_r       <= 1'b0;
            z_rise_r  <= 1'b0;
        end else if (!En) begin
            z_rise_r  <= 1'b0;
        end else if (!m_s) begin
            state_r   <= ST_IDLE;
            run_len_r <= {CW{1'b0}};
            z_r       <= 1'b0;
            z_rise_r  <= 1'b0;
        end else begin
            run_len_r <= run_inc_s;
            case (state_r)
                ST_IDLE, ST_RUN: begin
                    if (run_inc_s >= thr_s) begin
                        state_r   <= ST_HIT;
                        z_r       <= 1'b1;
                        z_rise_r  <= 1'b1;
                        evt_cnt_r <= evt_inc_s;
                    end else begin
                        state_r   <= ST_RUN;
                        z_r       <= 1'b0;
                        z_rise_r  <= 1'b0;
                    end
                end
                ST_HIT: begin
                    // Threshold changes never drop HIT; only a mismatch does.
                    state_r  <= ST_HIT;
                    z_r      <= 1'b1;
                    z_rise_r <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    z_r      <= 1'b0;
                    z_rise_r <= 1'b0;
                end
            endcase
        end
    end

    assign z       = z_r;
    assign z_rise  = z_rise_r;
    assign run_len = run_len_r;
    assign evt_cnt = evt_cnt_r;

endmodule
